// File: rtl/dac714_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac714_serial_tx                                                           |
// | Saturates a 32-bit ramp sample to 16 bits and shifts it MSB-first into a   |
// | DAC714 over CS/SCLK/SDI, then pulses nLDAC. One-deep pending buffer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dac714_serial_tx #(
    parameter int CLK_DIV     = 4,
    parameter int LATCH_WIDTH = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        DACStrobe,
    input  logic [31:0] Yis,
    output logic        Busy,
    output logic        Sat,
    output logic        Overrun,
    output logic        nDAC_CS,
    output logic        DAC_SCLK,
    output logic        DAC_SDI,
    output logic        nDAC_LDAC
);

    localparam logic [7:0] c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_latch_last = 8'(LATCH_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_CS_HOLD  = 3'd4,
        S_LATCH    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic [31:0] r_hold;
    logic        r_pending;
    logic        r_busy;
    logic        r_sat;
    logic        r_overrun;
    logic        r_cs_n;
    logic        r_sclk;
    logic        r_ldac_n;

    logic        w_clip_hi;
    logic        w_clip_lo;
    logic [15:0] w_word;
    logic        w_overrun;
    logic        w_shift_step;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        // In range exactly when bits 31..15 are all equal (sign extension).
        w_clip_hi    = ~r_hold[31] & (|r_hold[30:15]);
        w_clip_lo    = r_hold[31] & ~(&r_hold[30:15]);
        w_word       = w_clip_hi ? 16'h7FFF : (w_clip_lo ? 16'h8000 : r_hold[15:0]);
        // The value held during LOAD is being consumed, not lost.
        w_overrun    = DACStrobe & r_pending & (r_state != S_LOAD);
        w_shift_step = (r_state == S_SHIFT_HI) && (r_cnt == c_div_last) && (r_bit != 4'd0);
        case (r_state)
            S_IDLE:     if (DACStrobe || r_pending) w_next = S_LOAD;
            S_LOAD:     w_next = S_SHIFT_LO;
            S_SHIFT_LO: if (r_cnt == c_div_last) w_next = S_SHIFT_HI;
            S_SHIFT_HI: if (r_cnt == c_div_last)
                            w_next = (r_bit == 4'd0) ? S_CS_HOLD : S_SHIFT_LO;
            S_CS_HOLD:  if (r_cnt == c_div_last) w_next = S_LATCH;
            S_LATCH:    if (r_cnt == c_latch_last)
                            w_next = (r_pending || DACStrobe) ? S_LOAD : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= 8'd0;
            r_bit     <= 4'd0;
            r_shift   <= 16'd0;
            r_hold    <= 32'd0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_ldac_n  <= 1'b1;
        end else begin
            r_cnt <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;

            if (r_state == S_LOAD) begin
                r_shift <= w_word;
                r_bit   <= 4'd15;
            end else if (w_shift_step) begin
                r_shift <= {r_shift[14:0], 1'b0};
                r_bit   <= r_bit - 4'd1;
            end

            if (DACStrobe) begin
                r_hold    <= Yis;
                r_pending <= (r_state != S_IDLE);
            end else if (r_state == S_LOAD) begin
                r_pending <= 1'b0;
            end

            // Pin registers follow the state being entered, so pins track the FSM.
            r_busy    <= (w_next != S_IDLE);
            r_cs_n    <= ~((w_next == S_SHIFT_LO) || (w_next == S_SHIFT_HI));
            r_sclk    <= (w_next == S_SHIFT_HI);
            r_ldac_n  <= (w_next != S_LATCH);
            r_sat     <= (r_state == S_LOAD) && (w_clip_hi || w_clip_lo);
            r_overrun <= w_overrun;
        end
    end

    assign Busy      = r_busy;
    assign Sat       = r_sat;
    assign Overrun   = r_overrun;
    assign nDAC_CS   = r_cs_n;
    assign DAC_SCLK  = r_sclk;
    assign DAC_SDI   = r_shift[15];
    assign nDAC_LDAC = r_ldac_n;

endmodule
`default_nettype wire

// File: tb/tb_dac714_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dac714_serial_tx                                                        |
// | Scoreboard bench: expected words queued at strobe, checked per frame.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dac714_serial_tx;

    localparam int C_DIV   = 4;
    localparam int C_LW    = 2;
    localparam int C_FRAME = 1 + 32 * C_DIV + C_DIV + C_LW;

    logic        clk = 1'b0;
    logic        Reset;
    logic        DACStrobe;
    logic [31:0] Yis;
    logic        Busy, Sat, Overrun, nDAC_CS, DAC_SCLK, DAC_SDI, nDAC_LDAC;

    logic        Strobe2;
    logic [31:0] Yis2;
    logic        b_busy, b_sat, b_ovr, b_cs_n, b_sclk, b_sdi, b_ldac_n;

    always #5 clk = ~clk;

    dac714_serial_tx #(.CLK_DIV(C_DIV), .LATCH_WIDTH(C_LW)) dut (
        .clk(clk), .Reset(Reset), .DACStrobe(DACStrobe), .Yis(Yis),
        .Busy(Busy), .Sat(Sat), .Overrun(Overrun), .nDAC_CS(nDAC_CS),
        .DAC_SCLK(DAC_SCLK), .DAC_SDI(DAC_SDI), .nDAC_LDAC(nDAC_LDAC)
    );

    dac714_serial_tx #(.CLK_DIV(2), .LATCH_WIDTH(1)) dut2 (
        .clk(clk), .Reset(Reset), .DACStrobe(Strobe2), .Yis(Yis2),
        .Busy(b_busy), .Sat(b_sat), .Overrun(b_ovr), .nDAC_CS(b_cs_n),
        .DAC_SCLK(b_sclk), .DAC_SDI(b_sdi), .nDAC_LDAC(b_ldac_n)
    );

    typedef struct {
        logic [15:0] word;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame monitor for the default-parameter instance.
    logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_prev_ldac = 1'b1, m_prev_busy = 1'b0;
    logic [15:0] m_word = 16'd0;
    logic        m_sat_seen = 1'b0;
    int m_nbits = 0, m_run = 0, m_bad = 0, m_busy_run = 0, m_ldac_run = 0, m_gap = 0;
    int last_busy_len = 0, last_ldac_len = 0, last_gap = 0;
    int ldac_pulses = 0, ovr_count = 0, ovr_cyc = 0;

    always @(negedge clk) begin
        if (Reset) begin
            m_nbits    = 0;
            m_word     = 16'd0;
            m_bad      = 0;
            m_sat_seen = 1'b0;
            m_busy_run = 0;
            m_ldac_run = 0;
        end else begin
            if (Overrun) begin
                ovr_count++;
                ovr_cyc = cyc;
            end
            if (Sat) m_sat_seen = 1'b1;
            if (Busy) m_busy_run++;
            else if (m_prev_busy) begin
                last_busy_len = m_busy_run;
                m_busy_run    = 0;
            end
            if (!nDAC_LDAC) m_ldac_run++;
            else if (!m_prev_ldac) begin
                last_ldac_len = m_ldac_run;
                m_ldac_run    = 0;
                ldac_pulses++;
            end
            if (nDAC_LDAC && !m_prev_ldac) m_gap = 0;
            else m_gap++;

            if (!nDAC_CS && m_prev_cs) begin
                last_gap = m_gap;
                m_nbits  = 0;
                m_word   = 16'd0;
                m_bad    = 0;
                m_run    = 1;
            end else if (!nDAC_CS) begin
                if (DAC_SCLK == m_prev_sclk) m_run++;
                else begin
                    if (m_run != C_DIV) m_bad++;
                    m_run = 1;
                    if (DAC_SCLK) begin
                        m_word = {m_word[14:0], DAC_SDI};
                        m_nbits++;
                    end
                end
            end else if (!m_prev_cs) begin
                if (m_prev_sclk && m_run != C_DIV) m_bad++;
                if (sb.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
                else begin
                    m_exp = sb.pop_front();
                    check("word", {16'd0, m_word}, {16'd0, m_exp.word});
                    check("sat", {31'd0, m_sat_seen}, {31'd0, m_exp.sat});
                    check("nbits", m_nbits, 16);
                    check("sclk_phase", m_bad, 0);
                end
                m_sat_seen = 1'b0;
            end
        end
        m_prev_cs   = nDAC_CS;
        m_prev_sclk = DAC_SCLK;
        m_prev_ldac = nDAC_LDAC;
        m_prev_busy = Busy;
    end

    task automatic strobe(input logic [31:0] v);
        DACStrobe = 1'b1;
        Yis       = v;
        @(negedge clk);
        DACStrobe = 1'b0;
        Yis       = $urandom;
    endtask

    task automatic send(input logic [31:0] v, input logic [15:0] w, input logic s);
        exp_t e;
        e.word = w;
        e.sat  = s;
        sb.push_back(e);
        strobe(v);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (Busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, Busy}, 32'd0);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_cs"},   {31'd0, nDAC_CS},   32'd1);
        check({pfx, "_sclk"}, {31'd0, DAC_SCLK},  32'd0);
        check({pfx, "_sdi"},  {31'd0, DAC_SDI},   32'd0);
        check({pfx, "_ldac"}, {31'd0, nDAC_LDAC}, 32'd1);
        check({pfx, "_busy"}, {31'd0, Busy},      32'd0);
        check({pfx, "_sat"},  {31'd0, Sat},       32'd0);
        check({pfx, "_ovr"},  {31'd0, Overrun},   32'd0);
    endtask

    task automatic run_small(input logic [31:0] v, input logic [15:0] w);
        int          n = 0, busy_len = 0, ldac_len = 0, bits = 0, run = 0, bad = 0;
        logic        in_frame = 1'b0, prev_sclk = 1'b0;
        logic [15:0] word = 16'd0;
        Strobe2 = 1'b1;
        Yis2    = v;
        @(negedge clk);
        Strobe2 = 1'b0;
        while (b_busy && n < 300) begin
            busy_len++;
            if (!b_ldac_n) ldac_len++;
            if (!b_cs_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    run      = 1;
                end else if (b_sclk == prev_sclk) run++;
                else begin
                    if (run != 2) bad++;
                    run = 1;
                    if (b_sclk) begin
                        word = {word[14:0], b_sdi};
                        bits++;
                    end
                end
            end else if (in_frame) begin
                if (prev_sclk && run != 2) bad++;
                in_frame = 1'b0;
            end
            prev_sclk = b_sclk;
            @(negedge clk);
            n++;
        end
        check("div2_timeout", {31'd0, b_busy}, 32'd0);
        check("div2_busy_len", busy_len, 68);
        check("div2_word", {16'd0, word}, {16'd0, w});
        check("div2_nbits", bits, 16);
        check("div2_phase", bad, 0);
        check("div2_ldac_len", ldac_len, 1);
        check("div2_sat", {31'd0, b_sat}, 32'd0);
        check("div2_ovr", {31'd0, b_ovr}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ovr0, pulses0, c_cyc, n;
        Reset     = 1'b1;
        DACStrobe = 1'b0;
        Yis       = 32'd0;
        Strobe2   = 1'b0;
        Yis2      = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        Reset = 1'b0;
        @(negedge clk);

        // Basic frame
        send(32'h0000_1234, 16'h1234, 1'b0);
        wait_idle(400);
        check("busy_len", last_busy_len, C_FRAME);
        check("ldac_len", last_ldac_len, C_LW);

        // Saturation corners
        send(32'h0001_2345, 16'h7FFF, 1'b1);
        wait_idle(400);
        send(32'hFFFF_0000, 16'h8000, 1'b1);
        wait_idle(400);
        send(32'hFFFF_8000, 16'h8000, 1'b0);
        wait_idle(400);

        // A, B, C strobes: B overwritten by C
        ovr0 = ovr_count;
        send(32'h0000_0AAA, 16'h0AAA, 1'b0);
        repeat (9) @(negedge clk);
        strobe(32'h0000_0BBB);
        repeat (9) @(negedge clk);
        c_cyc = cyc;
        send(32'h0000_0CCC, 16'h0CCC, 1'b0);
        wait_idle(800);
        check("ovr_count", ovr_count - ovr0, 1);
        check("ovr_time", ovr_cyc - c_cyc, 1);
        check("b2b_gap", last_gap, 1);
        check("b2b_busy_len", last_busy_len, 2 * C_FRAME);

        // Reset in the 8th SCLK high phase
        pulses0 = ldac_pulses;
        strobe(32'h0000_5A5A);
        n = 0;
        while (!(m_nbits == 8 && DAC_SCLK) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("sclk8_timeout", {31'd0, DAC_SCLK}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async");
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_ldac", ldac_pulses, pulses0);
        send(32'h0000_0F0F, 16'h0F0F, 1'b0);
        wait_idle(400);
        check("post_rst_ldac", ldac_pulses, pulses0 + 1);

        // Strobe in the final LATCH cycle
        send(32'h0000_1111, 16'h1111, 1'b0);
        n = 0;
        while (nDAC_LDAC && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (C_LW - 1) @(negedge clk);
        check("in_last_latch", {31'd0, nDAC_LDAC}, 32'd0);
        ovr0 = ovr_count;
        send(32'hFFFF_EEEE, 16'hEEEE, 1'b0);
        wait_idle(800);
        check("latch_ovr", ovr_count - ovr0, 0);
        check("latch_gap", last_gap, 1);
        check("latch_busy_len", last_busy_len, 2 * C_FRAME);

        // Minimum divider instance
        run_small(32'hFFFF_A5C3, 16'hA5C3);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
